corrected_mul_seq: RTL and testbench

CORRECTED_MUL_SEQ -- requirements
Module: corrected_mul_seq

---
 rtl/corrected_mul_seq_pkg.sv | 13 +
 rtl/corrected_mul_seq_tile.sv | 24 ++
 rtl/corrected_mul_seq.sv | 135 +++++++++++++
 tb/tb_corrected_mul_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/corrected_mul_seq_pkg.sv
// Shared definitions for the sequential radix-4 tiled multiplier.
// Holds the controller state encoding and the width of one 2x2 tile product.
package corrected_mul_seq_pkg;

  localparam int TILE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/corrected_mul_seq_tile.sv
// Combinational 2x2-bit multiplier tile: an exact product and a cheap raw approximation,
// with a flag raised whenever the two disagree.
module mul2x2_tile
  import corrected_mul_seq_pkg::*;
(
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  input  logic              corr_en,
  output logic [TILE_W-1:0] p,
  output logic              mismatch
);

  logic [TILE_W-1:0] raw;
  logic [TILE_W-1:0] exact;

  always_comb begin
    // Raw tile keeps only the a[1]&b[1] term (weight 4) and a[0] at weight 2.
    raw      = {1'b0, a[1] & b[1], a[0], 1'b0};
    exact    = {2'b00, a} * {2'b00, b};
    mismatch = (raw != exact);
    p        = corr_en ? exact : raw;
  end

endmodule

// File: rtl/corrected_mul_seq.sv
// Sequential unsigned multiplier: one 2x2 tile is reused for every radix-4 digit pair,
// accumulating shifted tile products and counting tiles where raw and exact differ.
module corrected_mul_seq
  import corrected_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [WIDTH-1:0]                             A,
  input  logic [WIDTH-1:0]                             B,
  input  logic                                         corr_en,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [2*WIDTH-1:0]                           P,
  output logic [$clog2((WIDTH/2)*(WIDTH/2)+1)-1:0]     corr_hits
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N * N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               corr_q, corr_d;
  logic [IW-1:0]      i_q, i_d;
  logic [IW-1:0]      j_q, j_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      hits_q, hits_d;

  logic [1:0]         a_dig;
  logic [1:0]         b_dig;
  logic [TILE_W-1:0]  tile_p;
  logic               tile_mis;
  logic [IW:0]        shift_digits;
  logic [2*WIDTH-1:0] tile_ext;
  logic [2*WIDTH-1:0] addend;

  always_comb begin
    a_dig        = a_q[{i_q, 1'b0} +: 2];
    b_dig        = b_q[{j_q, 1'b0} +: 2];
    shift_digits = {1'b0, i_q} + {1'b0, j_q};
    tile_ext     = '0;
    tile_ext[TILE_W-1:0] = tile_p;
    addend       = tile_ext << {shift_digits, 1'b0};
  end

  mul2x2_tile u_tile (
    .a        (a_dig),
    .b        (b_dig),
    .corr_en  (corr_q),
    .p        (tile_p),
    .mismatch (tile_mis)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    corr_d  = corr_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    hits_d  = hits_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          corr_d  = corr_en;
          acc_d   = '0;
          hits_d  = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + addend;
        if (tile_mis) begin
          hits_d = hits_q + CW'(1);
        end
        // j is the inner digit index; the (LAST, LAST) tile ends the pass.
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      corr_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      corr_q  <= corr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      hits_q  <= hits_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = acc_q;
  assign corr_hits = hits_q;

endmodule

// File: tb/tb_corrected_mul_seq.sv
// Self-checking bench: WIDTH=8 and WIDTH=2 instances compared against a digit-level
// arithmetic model, with directed, backpressure, reset and random back-to-back traffic.
module tb_corrected_mul_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        iv8 = 1'b0, ce8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8;
  logic [15:0] p8;
  logic [4:0]  h8;

  logic        iv2 = 1'b0, ce2 = 1'b0, or2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        ir2, ov2;
  logic [3:0]  p2;
  logic [0:0]  h2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp8_p = '0;
  logic [4:0]  exp8_h = '0;

  corrected_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .corr_en(ce8), .out_valid(ov8), .out_ready(or8), .P(p8), .corr_hits(h8)
  );

  corrected_mul_seq #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
    .corr_en(ce2), .out_valid(ov2), .out_ready(or2), .P(p2), .corr_hits(h2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: sum over digit pairs of the selected tile value, weighted by 4^(i+j).
  function automatic int tile_raw(int a, int b);
    return 4 * ((a >> 1) & (b >> 1) & 1) + 2 * (a & 1);
  endfunction

  function automatic longint model_p(int w, int a, int b, bit ce);
    longint acc = 0;
    for (int i = 0; i < w / 2; i++) begin
      for (int j = 0; j < w / 2; j++) begin
        int da = (a >> (2 * i)) & 3;
        int db = (b >> (2 * j)) & 3;
        acc += longint'(ce ? da * db : tile_raw(da, db)) << (2 * (i + j));
      end
    end
    return acc & ((64'd1 << (2 * w)) - 1);
  endfunction

  function automatic int model_h(int w, int a, int b);
    int h = 0;
    for (int i = 0; i < w / 2; i++) begin
      for (int j = 0; j < w / 2; j++) begin
        int da = (a >> (2 * i)) & 3;
        int db = (b >> (2 * j)) & 3;
        if (tile_raw(da, db) != da * db) h++;
      end
    end
    return h;
  endfunction

  // Continuous compare: whenever the 8-bit result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov8 === 1'b1) begin
      chk("p8_cmp", p8, exp8_p);
      chk("h8_cmp", h8, exp8_h);
      chk("ir8_busy", ir8, 0);
    end
  end

  task automatic run8(input int a, input int b, input bit ce, input int hold, input bit pulse,
                      input bit use_p, input int lit_p, input bit use_h, input int lit_h);
    int n;
    int lat;
    n = 0;
    while (ir8 !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ir8_wait", ir8, 1);
    exp8_p = 16'(model_p(8, a, b, ce));
    exp8_h = 5'(model_h(8, a, b));
    a8 = 8'(a); b8 = 8'(b); ce8 = ce; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("ov8_after_accept", ov8, 0);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 100) begin
      // Operands, corr_en, out_ready and in_valid wiggle during RUN and must be ignored.
      a8 = 8'($urandom); b8 = 8'($urandom); ce8 = 1'($urandom);
      or8 = 1'($urandom); iv8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0; or8 = 1'b0;
    chk("latency8", lat, 16);
    if (use_p) chk("p8_literal", p8, lit_p);
    if (use_h) chk("h8_literal", h8, lit_h);
    for (int k = 0; k < hold; k++) begin
      if (pulse) begin
        iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(posedge clk); #1;
      iv8 = 1'b0;
      chk("ov8_hold", ov8, 1);
      chk("ir8_hold", ir8, 0);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("ov8_after_hs", ov8, 0);
    chk("ir8_after_hs", ir8, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ir8", ir8, 1);
    chk("rst_ov8", ov8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_h8", h8, 0);
    chk("rst_ov2", ov2, 0);

    chk("model_255", model_p(8, 255, 255, 1), 65025);
    chk("model_255_h", model_h(8, 255, 255), 16);
    chk("model_3_raw", model_p(8, 3, 3, 0), 174);
    chk("model_3_exact", model_p(8, 3, 3, 1), 9);
    chk("model_3_h", model_h(8, 3, 3), 4);
    chk("model_12x10", model_p(8, 12, 10, 1), 120);

    @(posedge clk); #1;
    rst_n = 1'b1;

    // Every digit of 255 is 3, so all 16 tiles differ (raw 6 vs exact 9).
    run8(255, 255, 1'b1, 0, 1'b0, 1'b1, 65025, 1'b1, 16);
    run8(3, 3, 1'b0, 0, 1'b0, 1'b1, 174, 1'b1, 4);
    run8(3, 3, 1'b1, 0, 1'b0, 1'b1, 9, 1'b1, 4);
    run8(200, 77, 1'b1, 5, 1'b1, 1'b1, 15400, 1'b0, 0);

    // Abort mid-RUN with an asynchronous reset.
    a8 = 8'd99; b8 = 8'd45; ce8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("busy_before_rst", ir8, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_ir8", ir8, 1);
    chk("abort_ov8", ov8, 0);
    chk("abort_p8", p8, 0);
    chk("abort_h8", h8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run8(12, 10, 1'b1, 0, 1'b0, 1'b1, 120, 1'b0, 0);

    // Exhaustive WIDTH=2.
    for (int ce = 0; ce < 2; ce++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          int lat;
          chk("ir2_idle", ir2, 1);
          a2 = 2'(a); b2 = 2'(b); ce2 = 1'(ce); iv2 = 1'b1;
          @(posedge clk); #1;
          iv2 = 1'b0;
          lat = 0;
          while (ov2 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          chk("latency2", lat, 1);
          chk("p2", p2, model_p(2, a, b, 1'(ce)));
          chk("h2", h2, model_h(2, a, b));
          or2 = 1'b1;
          @(posedge clk); #1;
          or2 = 1'b0;
        end
      end
    end

    // Random back-to-back exact products.
    for (int k = 0; k < 40; k++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      run8(ra, rb, 1'b1, int'($urandom_range(0, 2)), 1'b0, 1'b1, ra * rb, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
